// File: rtl/timera_tar_ctrl.sv
// ---------------------------------------------------------------------------------------------
// timera_tar_ctrl
//  Sequencing controller for the TimerA count datapath. Holds TAxR and TAxCTL, turns the
//  asynchronous pre-divided TimerClock into a one-MCLK tick, loads TAxR from the count
//  block's next value on each tick while running, and arbitrates CPU writes against counting.
//  Also produces the TACLR strobe, the EQU0 compare and the TAIFG interrupt request.
//
// Parameters
//  SYNC_STAGES  TimerClock synchroniser depth (2..4)
//
// Ports
//  MCLK        in   system clock
//  reset       in   synchronous active-high reset
//  TimerClock  in   pre-divided timer clock, asynchronous to MCLK
//  ctl_we      in   CPU write strobe for TAxCTL
//  tar_we      in   CPU write strobe for TAxR
//  wdata       in   CPU write data [15:0]
//  taifg_clr   in   TAIFG clear strobe (TAIV read)
//  CCR0        in   compare-0 value [15:0]
//  TAxRnew     in   next count value from the count block [15:0]
//  TAIFGset    in   count block wrap indication (level)
//  TAxR        out  current count [15:0]
//  TAxCTL      out  control readback [15:0]
//  MC          out  mode control [1:0]
//  EQU0        out  TAxR == CCR0
//  wTACLR      out  one-cycle clear strobe to the count block
//  tick        out  synchronised TimerClock rising-edge pulse
//  TAIFG_irq   out  TAIE & TAIFG
// ---------------------------------------------------------------------------------------------
module timera_tar_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        MCLK,
   input  logic        reset,
   input  logic        TimerClock,
   input  logic        ctl_we,
   input  logic        tar_we,
   input  logic [15:0] wdata,
   input  logic        taifg_clr,
   input  logic [15:0] CCR0,
   input  logic [15:0] TAxRnew,
   input  logic        TAIFGset,
   output logic [15:0] TAxR,
   output logic [15:0] TAxCTL,
   output logic [1:0]  MC,
   output logic        EQU0,
   output logic        wTACLR,
   output logic        tick,
   output logic        TAIFG_irq
);

   typedef enum logic [1:0] {
      StStop = 2'd0,
      StRun  = 2'd1,
      StClr  = 2'd2
   } tarStateT;

   tarStateT    stateQ, stateD;
   logic [15:0] taxrQ, taxrD;
   logic [1:0]  tasselQ, idQ, mcQ;
   logic        taieQ, taifgQ, taifgD;

   // syncQ[SYNC_STAGES-1] is the last synchroniser stage, syncQ[SYNC_STAGES] the edge flop
   logic [SYNC_STAGES:0] syncQ;
   logic                 tickQ;

   logic clrWrite;
   logic runTick;
   logic hwSet;

   assign clrWrite = ctl_we & wdata[2];
   assign runTick  = (stateQ == StRun) & tickQ;
   // A wrap only flags when the tick actually won the TAxR arbitration
   assign hwSet    = runTick & TAIFGset & ~clrWrite & ~tar_we;

   // -------------------------------------------------------------------------------------------
   // Synchroniser and tick generation
   // -------------------------------------------------------------------------------------------
   always_ff @(posedge MCLK) begin
      if (reset) begin
         syncQ <= '0;
         tickQ <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-1:0], TimerClock};
         tickQ <= syncQ[SYNC_STAGES-1] & ~syncQ[SYNC_STAGES];
      end
   end

   // -------------------------------------------------------------------------------------------
   // FSM next state
   // -------------------------------------------------------------------------------------------
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         // mcQ already holds the MC written alongside TACLR
         StClr:   stateD = (mcQ != 2'd0) ? StRun : StStop;
         default: stateD = stateQ;
      endcase
      if (ctl_we) begin
         if (wdata[2]) begin
            stateD = StClr;
         end else if (wdata[5:4] != 2'd0) begin
            stateD = StRun;
         end else begin
            stateD = StStop;
         end
      end
   end

   // -------------------------------------------------------------------------------------------
   // TAxR and TAIFG next values
   // -------------------------------------------------------------------------------------------
   always_comb begin
      taxrD = taxrQ;
      if (clrWrite || (stateQ == StClr)) begin
         taxrD = 16'h0000;
      end else if (tar_we) begin
         taxrD = wdata;
      end else if (runTick) begin
         taxrD = TAxRnew;
      end
   end

   always_comb begin
      taifgD = taifgQ;
      if (hwSet || (ctl_we && wdata[0])) begin
         taifgD = 1'b1;
      end else if (taifg_clr || ctl_we) begin
         taifgD = 1'b0;
      end
   end

   // -------------------------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------------------------
   always_ff @(posedge MCLK) begin
      if (reset) begin
         stateQ  <= StStop;
         taxrQ   <= 16'h0000;
         tasselQ <= 2'd0;
         idQ     <= 2'd0;
         mcQ     <= 2'd0;
         taieQ   <= 1'b0;
         taifgQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         taxrQ  <= taxrD;
         taifgQ <= taifgD;
         if (ctl_we) begin
            tasselQ <= wdata[9:8];
            idQ     <= wdata[7:6];
            mcQ     <= wdata[5:4];
            taieQ   <= wdata[1];
         end
      end
   end

   // -------------------------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------------------------
   assign TAxR      = taxrQ;
   // TACLR (bit 2) is a strobe and always reads back as 0
   assign TAxCTL    = {6'b000000, tasselQ, idQ, mcQ, 1'b0, 1'b0, taieQ, taifgQ};
   assign MC        = mcQ;
   assign EQU0      = (taxrQ == CCR0);
   assign wTACLR    = (stateQ == StClr);
   assign tick      = tickQ;
   assign TAIFG_irq = taieQ & taifgQ;

endmodule
